// File: rtl/neural_network_dense_layer.sv
// rtl/neural_network_dense_layer.sv - fully-connected layer: fetch activations, MAC, bias, ReLU, saturate
// One neuron per pass: FETCH streams N_IN reads, DRAIN absorbs the last returned word, ACT finalises.
module neural_network_dense_layer #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 2,
    parameter int DW    = 8,
    parameter int FRAC  = 4,
    parameter int IAW   = 1,
    parameter int WAW   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    output logic                  in_trig,
    output logic [IAW-1:0]        in_addr,
    input  logic [DW-1:0]         in_data,
    input  logic                  wt_we,
    input  logic [WAW-1:0]        wt_addr,
    input  logic [DW-1:0]         wt_data,
    output logic [N_OUT*DW-1:0]   out_data,
    output logic                  ack_layer
);

    localparam int AW = 2*DW + $clog2(N_IN) + 1;
    localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int NW = 1 << WAW;
    localparam logic [DW-1:0] OMAX = {1'b0, {(DW-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, ACT, DONE} state_t;

    state_t                   state_q, state_d;
    logic [IAW-1:0]           i_q, i_d;
    logic [JW-1:0]            j_q, j_d;
    logic                     rd_v_q;
    logic [IAW-1:0]           rd_idx_q;
    logic signed [AW-1:0]     acc_q, acc_d;
    logic [N_OUT*DW-1:0]      out_q, out_d;
    logic                     armed_q, armed_d;

    logic [DW-1:0]            wt_mem [NW];
    logic [WAW-1:0]           w_idx, b_idx;
    logic signed [2*DW-1:0]   prod;
    logic signed [AW-1:0]     shifted, y;
    logic [DW-1:0]            bias, act_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            rd_v_q   <= 1'b0;
            rd_idx_q <= '0;
            acc_q    <= '0;
            out_q    <= '0;
            armed_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            rd_v_q   <= in_trig;
            rd_idx_q <= i_q;
            acc_q    <= acc_d;
            out_q    <= out_d;
            armed_q  <= armed_d;
        end
    end

    // Store is frozen for the whole run so every neuron sees one consistent weight set.
    always_ff @(posedge clk) begin
        if (wt_we && (state_q == IDLE || state_q == DONE)) begin
            wt_mem[wt_addr] <= wt_data;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req && armed_q) state_d = FETCH;
            FETCH:   if (i_q == IAW'(N_IN-1)) state_d = DRAIN;
            DRAIN:   state_d = ACT;
            ACT:     state_d = (j_q == JW'(N_OUT-1)) ? DONE : FETCH;
            DONE:    if (!req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_trig   = (state_q == FETCH);
        ack_layer = (state_q == DONE);
        in_addr   = i_q;
        out_data  = out_q;
    end

    assign w_idx   = WAW'(j_q) * WAW'(N_IN) + WAW'(rd_idx_q);
    assign b_idx   = WAW'(N_OUT*N_IN) + WAW'(j_q);
    assign prod    = $signed(in_data) * $signed(wt_mem[w_idx]);
    assign bias    = wt_mem[b_idx];
    assign shifted = acc_q >>> FRAC;
    assign y       = shifted + $signed({{(AW-DW){bias[DW-1]}}, bias});

    // y is non-negative past the ReLU test, so any set bit at or above DW-1 means overflow.
    always_comb begin
        if (y[AW-1])               act_val = '0;
        else if (|y[AW-2:DW-1])    act_val = OMAX;
        else                       act_val = y[DW-1:0];
    end

    always_comb begin
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        out_d   = out_q;
        armed_d = armed_q | ~req;
        if (state_q == IDLE && state_d == FETCH) armed_d = 1'b0;
        if (state_d == FETCH && state_q != FETCH) i_d = '0;
        else if (state_q == FETCH && state_d == FETCH) i_d = i_q + IAW'(1);
        if (rd_v_q) acc_d = acc_q + $signed({{(AW-2*DW){prod[2*DW-1]}}, prod});
        if (state_q == ACT) begin
            out_d[int'(j_q)*DW +: DW] = act_val;
            acc_d = '0;
            j_d   = (j_q == JW'(N_OUT-1)) ? '0 : j_q + JW'(1);
        end
    end

endmodule

// File: tb/tb_neural_network_dense_layer.sv
// tb/tb_neural_network_dense_layer.sv - scoreboard bench for the dense layer
module tb_neural_network_dense_layer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        in_trig;
    logic [0:0]  in_addr;
    logic [7:0]  in_data;
    logic        wt_we;
    logic [2:0]  wt_addr;
    logic [7:0]  wt_data;
    logic [15:0] out_data;
    logic        ack_layer;

    logic [7:0]  in_mem [2];
    logic [15:0] exp_q [$];
    int          cyc = 0;
    int          start_cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    neural_network_dense_layer dut (
        .clk(clk), .rst(rst), .req(req),
        .in_trig(in_trig), .in_addr(in_addr), .in_data(in_data),
        .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .out_data(out_data), .ack_layer(ack_layer)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_trig) in_data <= in_mem[in_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each ack rising edge and audits the read stream of that run.
    initial begin
        logic       ack_prev;
        int         trig_cnt;
        logic [3:0] addr_log;
        logic [15:0] e;
        ack_prev = 1'b0; trig_cnt = 0; addr_log = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                trig_cnt = 0; addr_log = '0; ack_prev = 1'b0;
            end else begin
                if (in_trig) begin
                    trig_cnt++;
                    addr_log = {addr_log[2:0], in_addr};
                end
                if (ack_layer && !ack_prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_ack", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e);
                        check("ack_latency", cyc - start_cyc, 9);
                        check("trig_count", trig_cnt, 4);
                        check("trig_addrs", addr_log, 4'b0101);
                    end
                    trig_cnt = 0; addr_log = '0;
                end
                ack_prev = ack_layer;
            end
        end
    end

    task automatic wr(input int a, input int d);
        wt_we = 1'b1; wt_addr = 3'(a); wt_data = 8'(d);
        @(negedge clk);
        wt_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_in(input int a0, input int a1);
        in_mem[0] = 8'(a0);
        in_mem[1] = 8'(a1);
    endtask

    task automatic wait_ack();
        int t = 0;
        while (!ack_layer && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("ack_seen", ack_layer, 1);
    endtask

    task automatic start(input logic [15:0] e);
        exp_q.push_back(e);
        start_cyc = cyc;
        req = 1'b1;
    endtask

    task automatic run(input logic [15:0] e, input int hold);
        start(e);
        wait_ack();
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("ack_hold", ack_layer, 1);
            check("trig_in_done", in_trig, 0);
        end
        req = 1'b0;
        @(negedge clk);
        check("ack_drop", ack_layer, 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req = 1'b0; wt_we = 1'b0; wt_addr = '0; wt_data = '0; in_data = '0;
        set_in(0, 0);
        repeat (3) @(negedge clk);
        check("rst_ack", ack_layer, 0);
        check("rst_trig", in_trig, 0);
        check("rst_addr", in_addr, 0);
        check("rst_out", out_data, 0);
        rst = 1'b1;
        @(negedge clk);

        // w0=(16,16) b0=8, w1=(-16,0) b1=0, in=(16,32) -> 56, 0
        wr(0, 16); wr(1, 16); wr(2, -16); wr(3, 0); wr(4, 8); wr(5, 0);
        set_in(16, 32);
        run(16'h0038, 3);
        check("addr_hold", in_addr, 1);
        run(16'h0038, 0);

        // req dropped mid-run: ack still arrives, for exactly one cycle
        start(16'h0038);
        repeat (2) @(negedge clk);
        req = 1'b0;
        wait_ack();
        @(negedge clk);
        check("ack_pulse", ack_layer, 0);
        @(negedge clk);

        // abort during neuron 1 fetch of address 1
        req = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_pre_trig", in_trig, 1);
        #2 rst = 1'b0;
        #1;
        check("abort_ack", ack_layer, 0);
        check("abort_out", out_data, 0);
        check("abort_trig", in_trig, 0);
        check("abort_addr", in_addr, 0);
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run(16'h0038, 0);

        // write lock: mid-run write ignored, IDLE write honoured
        start(16'h0038);
        repeat (2) @(negedge clk);
        wr(0, 0);
        wait_ack();
        req = 1'b0;
        repeat (2) @(negedge clk);
        run(16'h0038, 0);
        wr(0, 0);
        run(16'h0028, 0);

        // saturation: 127*127*2 = 32258 >>> 4 = 2016 -> 127
        wr(0, 127); wr(1, 127); wr(4, 0);
        set_in(127, 127);
        run(16'h007F, 0);

        // floor and ReLU: neuron1 = 80>>>4 - 2 = 3
        wr(0, 1); wr(1, 0); wr(2, 0); wr(3, 16); wr(4, 0); wr(5, -2);
        set_in(-1, 5);
        run(16'h0300, 0);
        wr(4, 1);
        run(16'h0300, 0);
        wr(0, 8); wr(4, 2);
        run(16'h0301, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
